// File: rtl/mem_array_pkg.sv
// Shared types and pointer helpers for the streaming flop-array memory.
package mem_array_pkg;

  // Controller states; IDLE is the only state that accepts start pulses.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_PAD   = 3'd3,
    ST_DUMP  = 3'd4
  } mem_state_t;

  // Row pointer direction: upward from row 0, or downward from the top row.
  localparam bit ADDR_UP   = 1'b0;
  localparam bit ADDR_DOWN = 1'b1;

  // First row visited by every pass (clear, load, pad, dump).
  function automatic int ptr_first(bit dir, int wa);
    return (dir == ADDR_DOWN) ? wa - 1 : 0;
  endfunction

  // Last row visited by every pass; the pointer's terminal count.
  function automatic int ptr_final(bit dir, int wa);
    return (dir == ADDR_DOWN) ? 0 : wa - 1;
  endfunction

  // One pointer step in the chosen direction.
  function automatic int ptr_next(bit dir, int cur);
    return (dir == ADDR_DOWN) ? cur - 1 : cur + 1;
  endfunction

endpackage

// File: rtl/mem_array_ptr.sv
// Loadable up/down row pointer with a terminal-count flag, shared by all passes.
module mem_array_ptr
  import mem_array_pkg::*;
#(
  parameter int WA  = 8,
  parameter int AW  = $clog2(WA),
  parameter bit DIR = ADDR_UP
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  output logic [AW-1:0] ptr,
  output logic          tc
);

  localparam logic [AW-1:0] FIRST_ROW = AW'(ptr_first(DIR, WA));
  localparam logic [AW-1:0] FINAL_ROW = AW'(ptr_final(DIR, WA));

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  // Load restarts a pass at the first row; otherwise step once per written/emitted row.
  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = FIRST_ROW;
    end else if (step) begin
      ptr_d = AW'(ptr_next(DIR, int'(ptr_q)));
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
  assign tc  = (ptr_q == FINAL_ROW);

endmodule

// File: rtl/mem_array_stream.sv
// Flop-array memory with stream load (with padding/overflow flags), stream dump
// and a registered random-access read port.
module mem_array_stream
  import mem_array_pkg::*;
#(
  parameter int            WA       = 8,
  parameter int            WB       = 8,
  parameter int            ADDR_DIR = 0,
  parameter logic [WB-1:0] FILL     = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_start,
  input  logic                     ld_start,
  input  logic                     dp_start,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [WB-1:0]            ld_data,
  input  logic                     ld_last,
  output logic                     dp_valid,
  input  logic                     dp_ready,
  output logic [WB-1:0]            dp_data,
  output logic                     dp_last,
  input  logic [$clog2(WA)-1:0]    rd_addr,
  output logic [WB-1:0]            rd_data,
  output logic                     busy,
  output logic [$clog2(WA+1)-1:0]  ld_rows,
  output logic                     ld_short,
  output logic                     ld_over
);

  localparam int            AW        = $clog2(WA);
  localparam int            CW        = $clog2(WA + 1);
  localparam logic [CW-1:0] ROWS_FULL = CW'(WA);
  localparam logic [AW:0]   DEPTH     = (AW + 1)'(WA);
  localparam bit            DIR       = (ADDR_DIR == 1) ? ADDR_DOWN : ADDR_UP;

  mem_state_t    state_q, state_d;
  logic [CW-1:0] rows_q, rows_d;
  logic          short_q, short_d;
  logic          over_q, over_d;
  logic [WB-1:0] rd_data_q, rd_data_d;

  logic [WB-1:0] mem_q [WA];

  logic          ptr_load;
  logic          ptr_step;
  logic          ptr_tc;
  logic [AW-1:0] ptr;
  logic          wr_en;
  logic [WB-1:0] wr_data;

  mem_array_ptr #(
    .WA  (WA),
    .AW  (AW),
    .DIR (DIR)
  ) u_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ptr_load),
    .step  (ptr_step),
    .ptr   (ptr),
    .tc    (ptr_tc)
  );

  // Next-state, pointer control, array write control and load bookkeeping.
  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    short_d  = short_q;
    over_d   = over_q;
    ptr_load = 1'b0;
    ptr_step = 1'b0;
    wr_en    = 1'b0;
    wr_data  = FILL;

    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d  = ST_CLEAR;
          ptr_load = 1'b1;
        end else if (ld_start) begin
          state_d  = ST_LOAD;
          ptr_load = 1'b1;
          rows_d   = '0;
          short_d  = 1'b0;
          over_d   = 1'b0;
        end else if (dp_start) begin
          state_d  = ST_DUMP;
          ptr_load = 1'b1;
        end
      end

      ST_CLEAR: begin
        wr_en = 1'b1;
        if (ptr_tc) begin
          state_d = ST_IDLE;
        end else begin
          ptr_step = 1'b1;
        end
      end

      ST_LOAD: begin
        if (ld_valid) begin
          // Rows beyond the array depth are accepted but dropped; the pointer
          // parks on the final row once the array is full.
          if (rows_q < ROWS_FULL) begin
            wr_en    = 1'b1;
            wr_data  = ld_data;
            rows_d   = rows_q + CW'(1);
            ptr_step = !ptr_tc;
          end else begin
            over_d = 1'b1;
          end
          if (ld_last) begin
            if (rows_d < ROWS_FULL) begin
              state_d = ST_PAD;
              short_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end

      ST_PAD: begin
        wr_en = 1'b1;
        if (ptr_tc) begin
          state_d = ST_IDLE;
        end else begin
          ptr_step = 1'b1;
        end
      end

      ST_DUMP: begin
        if (dp_ready) begin
          if (ptr_tc) begin
            state_d = ST_IDLE;
          end else begin
            ptr_step = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Random read: out-of-range addresses return the fill value.
  always_comb begin
    rd_data_d = FILL;
    if ({1'b0, rd_addr} < DEPTH) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  // Control, flag and read-data registers; array contents are deliberately not reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rows_q    <= '0;
      short_q   <= 1'b0;
      over_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rows_q    <= rows_d;
      short_q   <= short_d;
      over_q    <= over_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Array write port; one row per cycle at the shared pointer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[ptr] <= wr_data;
    end
  end

  // Dump presents the pointed row directly, so it stays stable while stalled.
  assign dp_valid = (state_q == ST_DUMP);
  assign dp_last  = dp_valid && ptr_tc;
  assign dp_data  = dp_valid ? mem_q[ptr] : '0;

  assign ld_ready = (state_q == ST_LOAD);
  assign busy     = (state_q != ST_IDLE);
  assign ld_rows  = rows_q;
  assign ld_short = short_q;
  assign ld_over  = over_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_mem_array_stream.sv
// Randomised scoreboard bench: one upward DUT and one downward DUT share stimulus.
module tb_mem_array_stream;

  localparam int WA = 8;
  localparam int WB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr_start = 1'b0;
  logic          ld_start = 1'b0;
  logic          dp_start = 1'b0;
  logic          ld_valid = 1'b0;
  logic          ld_last = 1'b0;
  logic          dp_ready = 1'b0;
  logic [WB-1:0] ld_data = '0;
  logic [2:0]    rd_addr = '0;

  logic          ld_ready [2];
  logic          dp_valid [2];
  logic          dp_last  [2];
  logic          busy     [2];
  logic          ld_short [2];
  logic          ld_over  [2];
  logic [WB-1:0] dp_data  [2];
  logic [WB-1:0] rd_data  [2];
  logic [3:0]    ld_rows  [2];

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [WB-1:0] exp_mem [2][WA];
  int            exp_rows = 0;
  bit            exp_short = 1'b0;
  bit            exp_over = 1'b0;
  logic [8:0]    exp_q0 [$];
  logic [8:0]    exp_q1 [$];

  bit            hold_valid [2];
  logic [8:0]    hold_beat  [2];

  mem_array_stream #(.WA(WA), .WB(WB), .ADDR_DIR(0), .FILL(8'hA5)) u_up (
    .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .ld_start(ld_start), .dp_start(dp_start),
    .ld_valid(ld_valid), .ld_ready(ld_ready[0]), .ld_data(ld_data), .ld_last(ld_last),
    .dp_valid(dp_valid[0]), .dp_ready(dp_ready), .dp_data(dp_data[0]), .dp_last(dp_last[0]),
    .rd_addr(rd_addr), .rd_data(rd_data[0]), .busy(busy[0]), .ld_rows(ld_rows[0]),
    .ld_short(ld_short[0]), .ld_over(ld_over[0])
  );

  mem_array_stream #(.WA(WA), .WB(WB), .ADDR_DIR(1), .FILL(8'h00)) u_dn (
    .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .ld_start(ld_start), .dp_start(dp_start),
    .ld_valid(ld_valid), .ld_ready(ld_ready[1]), .ld_data(ld_data), .ld_last(ld_last),
    .dp_valid(dp_valid[1]), .dp_ready(dp_ready), .dp_data(dp_data[1]), .dp_last(dp_last[1]),
    .rd_addr(rd_addr), .rd_data(rd_data[1]), .busy(busy[1]), .ld_rows(ld_rows[1]),
    .ld_short(ld_short[1]), .ld_over(ld_over[1])
  );

  always #5 clk = ~clk;

  function automatic logic [WB-1:0] fill_of(int k);
    return (k == 0) ? 8'hA5 : 8'h00;
  endfunction

  // i-th row of a stream lands here: upward instance counts up, downward counts down.
  function automatic int row_of(int k, int i);
    return (k == 0) ? i : WA - 1 - i;
  endfunction

  task automatic check_output(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while ((busy[0] || busy[1]) && cycles < 64) begin
      tick();
      cycles++;
    end
  endtask

  task automatic check_mem();
    for (int a = 0; a < WA; a++) begin
      rd_addr = 3'(a);
      tick();
      for (int k = 0; k < 2; k++) check_output($sformatf("rd_row%0d_inst%0d", a, k), rd_data[k], exp_mem[k][a]);
    end
  endtask

  task automatic check_status();
    for (int k = 0; k < 2; k++) begin
      check_output("ld_rows", ld_rows[k], exp_rows);
      check_output("ld_short", ld_short[k], exp_short);
      check_output("ld_over", ld_over[k], exp_over);
      check_output("busy_idle", busy[k], 0);
    end
  endtask

  task automatic check_reset_outputs();
    for (int k = 0; k < 2; k++) begin
      check_output("rst_ctrl", {busy[k], ld_ready[k], dp_valid[k], dp_last[k], ld_short[k], ld_over[k]}, 0);
      check_output("rst_rows", ld_rows[k], 0);
      check_output("rst_dp_data", dp_data[k], 0);
      check_output("rst_rd_data", rd_data[k], 0);
    end
  endtask

  task automatic apply_clear();
    int n;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int k = 0; k < 2; k++) check_output("busy_rise", busy[k], 1);
    wait_idle(n);
    check_output("clear_cycles", n, WA);
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < WA; a++) exp_mem[k][a] = fill_of(k);
    check_mem();
  endtask

  // Stream n rows with random gaps; seq selects data 0..n-1 instead of random bytes.
  task automatic apply_load(int n, bit seq, bit with_dump_start);
    logic [WB-1:0] d [$];
    int c;
    for (int i = 0; i < n; i++) d.push_back(seq ? WB'(i) : WB'($urandom_range(0, 255)));
    ld_start = 1'b1;
    dp_start = with_dump_start;
    tick();
    ld_start = 1'b0;
    dp_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check_output("ld_ready_on", ld_ready[k], 1);
      check_output("dp_not_started", dp_valid[k], 0);
      check_output("rows_cleared", ld_rows[k], 0);
    end
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        ld_valid = 1'b0;
        tick();
      end
      ld_valid  = 1'b1;
      ld_data   = d[i];
      ld_last   = (i == n - 1);
      clr_start = ($urandom_range(0, 5) == 0);
      tick();
      ld_valid  = 1'b0;
      ld_last   = 1'b0;
      clr_start = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < n && i < WA; i++) exp_mem[k][row_of(k, i)] = d[i];
      for (int i = n; i < WA; i++) exp_mem[k][row_of(k, i)] = fill_of(k);
    end
    exp_rows  = (n < WA) ? n : WA;
    exp_short = (n < WA);
    exp_over  = (n > WA);
    wait_idle(c);
    check_output("pad_cycles", c, (n < WA) ? WA - n : 0);
    check_status();
    check_mem();
  endtask

  // mode 0: always ready, 1: ready every other cycle, 2: random ready.
  task automatic apply_dump(int mode);
    int cyc = 0;
    for (int i = 0; i < WA; i++) begin
      exp_q0.push_back({(i == WA - 1), exp_mem[0][row_of(0, i)]});
      exp_q1.push_back({(i == WA - 1), exp_mem[1][row_of(1, i)]});
    end
    dp_start = 1'b1;
    tick();
    dp_start = 1'b0;
    for (int k = 0; k < 2; k++) check_output("dp_first", dp_valid[k], 1);
    while ((busy[0] || busy[1]) && cyc < 200) begin
      case (mode)
        0:       dp_ready = 1'b1;
        1:       dp_ready = cyc[0];
        default: dp_ready = 1'($urandom_range(0, 1));
      endcase
      clr_start = ($urandom_range(0, 7) == 0);
      tick();
      clr_start = 1'b0;
      cyc++;
    end
    dp_ready = 1'b0;
    for (int k = 0; k < 2; k++) check_output("dump_done", busy[k], 0);
    check_output("dump_left_up", exp_q0.size(), 0);
    check_output("dump_left_dn", exp_q1.size(), 0);
    exp_q0.delete();
    exp_q1.delete();
    check_mem();
  endtask

  task automatic apply_reset_mid_load();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_data  = WB'(i);
      tick();
      for (int k = 0; k < 2; k++) exp_mem[k][row_of(k, i)] = WB'(i);
    end
    ld_data = 8'h3C;
    rst_n   = 1'b0;
    tick();
    ld_valid = 1'b0;
    tick();
    check_reset_outputs();
    rst_n = 1'b1;
    exp_rows  = 0;
    exp_short = 1'b0;
    exp_over  = 1'b0;
    tick();
    check_status();
    check_mem();
  endtask

  // Monitor: pops the scoreboard on every dump handshake and checks stall stability.
  initial begin
    hold_valid[0] = 1'b0;
    hold_valid[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (hold_valid[k]) check_output("dump_hold", {dp_valid[k], dp_last[k], dp_data[k]}, {1'b1, hold_beat[k]});
        hold_valid[k] = 1'b0;
        if (dp_valid[k]) begin
          if (dp_ready) begin
            if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
              check_output("dump_extra", 1, 0);
            end else begin
              check_output($sformatf("dump_row_inst%0d", k), {dp_last[k], dp_data[k]},
                           (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front());
            end
          end else begin
            hold_valid[k] = 1'b1;
            hold_beat[k]  = {dp_last[k], dp_data[k]};
          end
        end
      end
    end
  end

  initial begin
    tick();
    tick();
    check_reset_outputs();
    rst_n = 1'b1;
    tick();

    apply_clear();
    apply_load(8, 1'b1, 1'b0);
    apply_dump(0);
    apply_load(7, 1'b1, 1'b0);
    apply_load(9, 1'b1, 1'b0);
    apply_dump(1);
    apply_reset_mid_load();
    apply_load(8, 1'b0, 1'b1);
    apply_dump(1);
    for (int r = 0; r < 6; r++) begin
      apply_load($urandom_range(1, 11), 1'b0, 1'b0);
      apply_dump(2);
    end
    apply_clear();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
